// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared UART state encoding and legal oversampling ratios
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [5:0] C_PRESCALE_8  = 6'd8;
  localparam logic [5:0] C_PRESCALE_16 = 6'd16;
  localparam logic [5:0] C_PRESCALE_32 = 6'd32;

  // Any ratio other than 16 or 32 falls back to 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    if (p == C_PRESCALE_16 || p == C_PRESCALE_32) begin
      return p;
    end
    return C_PRESCALE_8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_sampler : per-bit edge/bit counters and bit decision
// (UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting). Rev 1.0
// ------------------------------------------------------------------
module uart_rx_sampler #(
  parameter int BIT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 count_en_i,
  input  logic                 rx_i,
  input  logic [5:0]           prescale_i,
  output logic [BIT_CNT_W-1:0] bit_cnt_o,
  output logic                 sample_o,
  output logic                 bit_o,
  output logic                 wrap_o
);

  logic [5:0]           edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [5:0]           mid;
  logic [5:0]           last;

  assign mid       = {1'b0, prescale_i[5:1]};
  assign last      = prescale_i - 6'd1;
  assign wrap_o    = count_en_i && (edge_cnt_q == last);
  assign bit_cnt_o = bit_cnt_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clear_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (count_en_i) begin
      if (edge_cnt_q == last) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] votes_q;

  // Early votes at M-1 and M; the third vote is the live line at M+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      votes_q <= '0;
    end else if (count_en_i) begin
      if (edge_cnt_q == mid - 6'd1) votes_q[0] <= rx_i;
      if (edge_cnt_q == mid)        votes_q[1] <= rx_i;
    end
  end

  assign sample_o = count_en_i && (edge_cnt_q == mid + 6'd1);
  assign bit_o    = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_i) | (votes_q[1] & rx_i);
`else
  assign sample_o = count_en_i && (edge_cnt_q == mid);
  assign bit_o    = rx_i;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx : oversampling UART receiver with optional parity
// (optional build macro UART_RX_MAJORITY_VOTE_EN). Rev 1.0
// ------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int                   BIT_CNT_W     = $clog2(DATA_WIDTH + 4);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH);

  uart_state_e           state_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [5:0]            prescale_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_fail_q;
  logic                  stop_bad_q;
  logic                  rx_prev_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic                  start_det;
  logic                  count_en;
  logic                  clear;
  logic                  sample;
  logic                  bit_val;
  logic                  wrap;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  // rx_prev_q resets low so a line held low across reset is not taken as a start.
  assign start_det = (state_q == ST_IDLE) && rx_prev_q && !RX_IN;
  assign count_en  = (state_q != ST_IDLE) || start_det;
  assign clear     = ((state_q == ST_START) && sample && bit_val) ||
                     ((state_q == ST_STOP) && wrap);

  uart_rx_sampler #(
    .BIT_CNT_W (BIT_CNT_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .count_en_i (count_en),
    .rx_i       (RX_IN),
    .prescale_i (prescale_q),
    .bit_cnt_o  (bit_cnt),
    .sample_o   (sample),
    .bit_o      (bit_val),
    .wrap_o     (wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      prescale_q   <= C_PRESCALE_8;
      shift_q      <= '0;
      par_fail_q   <= 1'b0;
      stop_bad_q   <= 1'b0;
      rx_prev_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      rx_prev_q    <= RX_IN;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_det) begin
            state_q    <= ST_START;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            prescale_q <= legal_prescale(Prescale);
            par_fail_q <= 1'b0;
          end
        end
        ST_START: begin
          if (sample && bit_val) begin
            state_q <= ST_IDLE;
          end else if (wrap) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample) begin
            shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
          end
          if (wrap && (bit_cnt == LAST_DATA_BIT)) begin
            state_q <= par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (sample) begin
            par_fail_q <= bit_val != ((^shift_q) ^ par_typ_q);
          end
          if (wrap) begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            stop_bad_q <= !bit_val;
          end
          if (wrap) begin
            // Arm the start detector so a start bit right after the stop bit costs no cycle.
            state_q   <= ST_IDLE;
            rx_prev_q <= 1'b1;
            if (stop_bad_q) begin
              stp_err_q <= 1'b1;
            end else if (par_fail_q) begin
              par_err_q <= 1'b1;
            end else begin
              data_valid_q <= 1'b1;
              p_data_q     <= shift_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx : directed and randomized frames, outputs compared every cycle
// against a frame-level model that decodes the recorded line.
module tb_uart_rx;

  localparam int DW = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DEC_OFS = 1;
`else
  localparam int DEC_OFS = 0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          RX_IN    = 1'b1;
  logic          PAR_EN   = 1'b0;
  logic          PAR_TYP  = 1'b0;
  logic [5:0]    Prescale = 6'd8;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = -1;
  bit line [0:99999];

  bit            m_busy, m_prev, m_pe, m_pt;
  int            m_s, m_p;
  logic          m_dv, m_perr, m_serr;
  logic [DW-1:0] m_pd;

  int dv_cyc[$];
  int pe_cyc[$];
  int se_cyc[$];

  function automatic int legal_p(input logic [5:0] p);
    return (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
  endfunction

  // Decided value of bit b of the frame that started at cycle s.
  function automatic bit dec(input int s, input int b, input int p);
    int c;
    c = s + b * p + p / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    return (int'(line[c-1]) + int'(line[c]) + int'(line[c+1])) >= 2;
`else
    return line[c];
`endif
  endfunction

  always @(posedge clk) begin
    int            k, n;
    logic [DW-1:0] d;
    bit            stopb, parok;
    cyc = cyc + 1;
    line[cyc] = RX_IN;
    m_dv = 1'b0; m_perr = 1'b0; m_serr = 1'b0;
    if (!rst) begin
      m_busy = 1'b0; m_prev = 1'b0; m_pd = '0;
    end else if (!m_busy) begin
      if (m_prev && !RX_IN) begin
        m_busy = 1'b1; m_s = cyc; m_p = legal_p(Prescale); m_pe = PAR_EN; m_pt = PAR_TYP;
      end
      m_prev = RX_IN;
    end else begin
      k = cyc - m_s;
      n = 2 + DW + int'(m_pe);
      m_prev = RX_IN;
      if (k == m_p / 2 + DEC_OFS && dec(m_s, 0, m_p)) begin
        m_busy = 1'b0;
      end else if (k == n * m_p - 1) begin
        for (int i = 0; i < DW; i++) d[i] = dec(m_s, 1 + i, m_p);
        stopb = dec(m_s, n - 1, m_p);
        parok = !m_pe || (dec(m_s, 1 + DW, m_p) == ((^d) ^ m_pt));
        if (!stopb) m_serr = 1'b1;
        else if (!parok) m_perr = 1'b1;
        else begin m_dv = 1'b1; m_pd = d; end
        m_busy = 1'b0;
        m_prev = 1'b1;
      end
    end
    #1;
    checks = checks + 1;
    if ({data_valid, par_err, stp_err, P_DATA} !== {m_dv, m_perr, m_serr, m_pd}) begin
      errors = errors + 1;
      $display("FAIL cycle %0d outputs dv/pe/se/P_DATA: got %b%b%b/%h expected %b%b%b/%h",
               cyc, data_valid, par_err, stp_err, P_DATA, m_dv, m_perr, m_serr, m_pd);
    end
    if (data_valid === 1'b1) dv_cyc.push_back(cyc);
    if (par_err === 1'b1)    pe_cyc.push_back(cyc);
    if (stp_err === 1'b1)    se_cyc.push_back(cyc);
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      RX_IN = b;
    end
  endtask

  // s returns the cycle in which the DUT first samples the start bit low.
  task automatic send_frame(input logic [DW-1:0] d, input logic [5:0] pre, input bit pe,
                            input bit pt, input bit par_bit, input bit stop_bit,
                            input bit scramble, output int s);
    int p;
    p = legal_p(pre);
    @(negedge clk);
    PAR_EN = pe; PAR_TYP = pt; Prescale = pre; RX_IN = 1'b0;
    s = cyc + 1;
    drive(1'b0, 1);
    if (scramble) begin
      PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); Prescale = 6'($urandom);
    end
    drive(1'b0, p - 2);
    for (int i = 0; i < DW; i++) drive(d[i], p);
    if (pe) drive(par_bit, p);
    drive(stop_bit, p);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, ndv, npe, nse;
    drive(1'b1, 4);
    check("reset_p_data", int'(P_DATA), 0);
    check("reset_pulses", int'({data_valid, par_err, stp_err}), 0);
    @(negedge clk); rst = 1'b1;
    drive(1'b1, 4);

    // 0xA5, even parity, parity bit 0: valid frame seen 88 cycles after the first low sample
    send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s);
    drive(1'b1, 6);
    check("a5_dv_count", dv_cyc.size(), 1);
    check("a5_dv_latency", dv_cyc[dv_cyc.size()-1] + 1 - s, 88);
    check("a5_p_data", int'(P_DATA), 'hA5);

    // Same line, odd parity expected: parity error, data held
    send_frame(8'hA5, 6'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, s);
    drive(1'b1, 6);
    check("par_err_count", pe_cyc.size(), 1);
    check("par_err_latency", pe_cyc[pe_cyc.size()-1] + 1 - s, 88);
    check("par_err_no_dv", dv_cyc.size(), 1);
    check("par_err_p_data_held", int'(P_DATA), 'hA5);

    // 0x3C at 16x, no parity, stop bit low
    send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
    drive(1'b1, 6);
    check("stp_err_count", se_cyc.size(), 1);
    check("stp_err_latency", se_cyc[se_cyc.size()-1] + 1 - s, 160);
    check("stp_err_no_dv", dv_cyc.size(), 1);

    // 3-cycle glitch is rejected, then 0x55 is received
    @(negedge clk); Prescale = 6'd16; PAR_EN = 1'b0;
    drive(1'b0, 3);
    drive(1'b1, 30);
    check("glitch_no_pulse", dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 3);
    send_frame(8'h55, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    drive(1'b1, 6);
    check("glitch_next_dv", dv_cyc.size(), 2);
    check("glitch_next_data", int'(P_DATA), 'h55);
    check("glitch_next_latency", dv_cyc[dv_cyc.size()-1] + 1 - s, 160);

    // Back-to-back frames at 32x
    send_frame(8'h12, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    send_frame(8'hEF, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s2);
    drive(1'b1, 6);
    check("b2b_dv_count", dv_cyc.size(), 4);
    check("b2b_spacing", dv_cyc[3] - dv_cyc[2], 320);
    check("b2b_data", int'(P_DATA), 'hEF);

    // Reset in data bit 4 of 0x81, then a full 0x81 frame
    @(negedge clk); Prescale = 6'd8; PAR_EN = 1'b0; RX_IN = 1'b0;
    drive(1'b0, 7);
    drive(1'b1, 8);
    drive(1'b0, 24);
    drive(1'b0, 4);
    @(negedge clk); rst = 1'b0;
    #1;
    check("midrst_p_data", int'(P_DATA), 0);
    check("midrst_pulses", int'({data_valid, par_err, stp_err}), 0);
    drive(1'b1, 4);
    @(negedge clk); rst = 1'b1;
    drive(1'b1, 4);
    ndv = dv_cyc.size(); npe = pe_cyc.size(); nse = se_cyc.size();
    send_frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    drive(1'b1, 6);
    check("postrst_dv", dv_cyc.size() - ndv, 1);
    check("postrst_data", int'(P_DATA), 'h81);
    check("postrst_no_err", pe_cyc.size() + se_cyc.size(), npe + nse);

    // Randomized traffic
    for (int f = 0; f < 60; f++) begin
      logic [5:0]    pre;
      logic [DW-1:0] d;
      bit            pe, pt, pb, sb, scr;
      case ($urandom_range(0, 4))
        0:       pre = 6'd8;
        1:       pre = 6'd16;
        2:       pre = 6'd32;
        3:       pre = 6'($urandom);
        default: pre = 6'd16;
      endcase
      d   = DW'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      pb  = (^d) ^ pt;
      if ($urandom_range(0, 5) == 0) pb = ~pb;
      sb  = ($urandom_range(0, 6) != 0);
      scr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) begin
        Prescale = pre;
        drive(1'b0, $urandom_range(1, legal_p(pre) / 2 - 2));
        drive(1'b1, legal_p(pre));
      end
      send_frame(d, pre, pe, pt, pb, sb, scr, s);
      drive(1'b1, $urandom_range(0, 3));
    end
    drive(1'b1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
